// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
//   size_e  : access size encodings (byte/half/word/reserved)
//   resp_t  : response pipeline register payload
//   byte_en : byte-lane write enables for a size and byte offset
//   load_fmt: extracts and extends load data from a memory word
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  // Everything the response cycle needs, captured on the grant edge
  typedef struct packed {
    logic       valid;
    logic       port;
    logic       was_read;
    size_e      size;
    logic       uns;
    logic [1:0] off;
    logic       err;
  } resp_t;

  function automatic logic [LANES-1:0] byte_en(input size_e size, input logic [1:0] off);
    logic [LANES-1:0] be;
    be = '0;
    case (size)
      SZ_BYTE: be = LANES'(4'b0001 << off);
      SZ_HALF: be = LANES'(4'b0011 << off);
      SZ_WORD: be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] load_fmt(input logic [DATA_W-1:0] dout,
                                                 input size_e size,
                                                 input logic uns,
                                                 input logic [1:0] off);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = 8'(dout >> {off, 3'b000});
    h = off[1] ? dout[31:16] : dout[15:0];
    r = '0;
    case (size)
      SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      SZ_WORD: r = dout;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin arbiter with combinational grant.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-port request
//   gnt      : one-hot grant, same cycle as req, zero while rst
module dmem_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Reset to port 1 so that port 0 wins the first conflict
  logic last_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (|gnt) begin
      last_gnt <= gnt[1];
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) begin
        gnt = last_gnt ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester front end for a single-port data memory with a registered
// one-cycle read. Arbitrates, formats stores into byte lanes, flags illegal
// accesses, and returns extended load data one cycle after the grant.
//   clk, rst           : clock, synchronous active-high reset
//   req_i/we_i/size_i/uns_i/addr_i/wdata_i : per-port request (index = port)
//   gnt_o              : one-hot grant, combinational
//   rvalid_o/rdata_o/err_o : response, one cycle after grant
//   mem_addr_o/mem_din_o/mem_we_o/mem_dout_i : memory interface
// Optional DMEM_ARB_STATS_EN adds saturating grant/conflict/error counters.
module dmem_arbiter #(
  parameter int unsigned DEPTH_WORDS = 121,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_i,
  input  logic [1:0]             we_i,
  input  logic [1:0][1:0]        size_i,
  input  logic [1:0]             uns_i,
  input  logic [1:0][ADDR_W-1:0] addr_i,
  input  logic [1:0][31:0]       wdata_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   err_o,
  output logic [31:0]            mem_addr_o,
  output logic [31:0]            mem_din_o,
  output logic [3:0]             mem_we_o,
  input  logic [31:0]            mem_dout_i
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]            stat_gnt0_o,
  output logic [31:0]            stat_gnt1_o,
  output logic [31:0]            stat_conflict_o,
  output logic [15:0]            stat_err_o
`endif
);

  import dmem_pkg::*;

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH_WORDS);

  logic              any_gnt;
  logic              sel;
  logic              s_we;
  logic              s_uns;
  size_e             s_size;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata;
  logic              s_err;
  resp_t             resp_q;
  resp_t             resp_d;

  dmem_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_i),
    .gnt (gnt_o)
  );

  // Select the granted port's request and classify it
  always_comb begin
    any_gnt = |gnt_o;
    sel     = gnt_o[1];
    s_we    = we_i[sel];
    s_uns   = uns_i[sel];
    s_size  = size_e'(size_i[sel]);
    s_addr  = addr_i[sel];
    s_wdata = wdata_i[sel];
    s_err   = 1'b0;
    case (s_size)
      SZ_HALF: s_err = s_addr[0];
      SZ_WORD: s_err = (s_addr[1:0] != 2'b00);
      SZ_RSVD: s_err = 1'b1;
      default: s_err = 1'b0;
    endcase
    if (s_addr[ADDR_W-1:2] >= DEPTH_IDX) begin
      s_err = 1'b1;
    end
  end

  // Memory drive during the grant cycle; errors never write
  always_comb begin
    mem_addr_o = '0;
    mem_din_o  = '0;
    mem_we_o   = '0;
    if (any_gnt) begin
      mem_addr_o = 32'(s_addr);
      case (s_size)
        SZ_BYTE: mem_din_o = {4{s_wdata[7:0]}};
        SZ_HALF: mem_din_o = {2{s_wdata[15:0]}};
        default: mem_din_o = s_wdata;
      endcase
      if (s_we && !s_err) begin
        mem_we_o = byte_en(s_size, s_addr[1:0]);
      end
    end
  end

  always_comb begin
    resp_d          = '0;
    resp_d.valid    = any_gnt;
    resp_d.port     = sel;
    resp_d.was_read = ~s_we;
    resp_d.size     = s_size;
    resp_d.uns      = s_uns;
    resp_d.off      = s_addr[1:0];
    resp_d.err      = s_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  // Response cycle; rst masks a pending response immediately
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    err_o    = 1'b0;
    if (resp_q.valid && !rst) begin
      rvalid_o = 2'(2'b01 << resp_q.port);
      err_o    = resp_q.err;
      if (resp_q.was_read && !resp_q.err) begin
        rdata_o = load_fmt(mem_dout_i, resp_q.size, resp_q.uns, resp_q.off);
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_gnt0_o     <= '0;
      stat_gnt1_o     <= '0;
      stat_conflict_o <= '0;
      stat_err_o      <= '0;
    end else begin
      if (gnt_o[0] && (stat_gnt0_o != '1)) begin
        stat_gnt0_o <= stat_gnt0_o + 32'd1;
      end
      if (gnt_o[1] && (stat_gnt1_o != '1)) begin
        stat_gnt1_o <= stat_gnt1_o + 32'd1;
      end
      if ((req_i == 2'b11) && (stat_conflict_o != '1)) begin
        stat_conflict_o <= stat_conflict_o + 32'd1;
      end
      if (any_gnt && s_err && (stat_err_o != '1)) begin
        stat_err_o <= stat_err_o + 16'd1;
      end
    end
  end
`endif

endmodule
